// File: rtl/sprite_compositor_ctrl_pkg.sv
// Shared types and constants for the sprite compositor: visible-area limits,
// register offsets, the per-sprite register record and colour expansion.
package vga_sprite_pkg;

  localparam int HACTIVE_PX = 640;
  localparam int VACTIVE    = 480;

  localparam logic [1:0] SPR_X    = 2'd0;
  localparam logic [1:0] SPR_Y    = 2'd1;
  localparam logic [1:0] SPR_CTRL = 2'd2;
  localparam logic [8:0] BG_ADDR  = 9'd32;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
  } sprite_regs_t;

  // Zero-padded expansion: low bits of each channel are left at 0.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] c);
    return {c[15:11], 3'b000, c[10:5], 2'b00, c[4:0], 3'b000};
  endfunction

endpackage

// File: rtl/sprite_compositor_ctrl_if.sv
// Avalon-MM write-only slave bus used to load the sprite register bank.
interface sprite_compositor_ctrl_if;
  logic        chipselect;
  logic        write;
  logic [8:0]  address;
  logic [31:0] writedata;

  modport slave  (input  chipselect, write, address, writedata);
  modport master (output chipselect, write, address, writedata);
endinterface

// File: rtl/sprite_compositor_ctrl_hit_unit.sv
// Per-sprite hit test and ROM address generation (pipeline stage 1).
// Sprites are clipped at the visible edge rather than wrapping.
module sprite_hit_unit
  import vga_sprite_pkg::*;
#(
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   i_px,
  input  logic [9:0]   i_vcount,
  input  sprite_regs_t i_regs,
  output logic         o_hit,
  output logic [9:0]   o_rom_addr
);

  logic [10:0] w_px, w_vc, w_x_end, w_y_end;
  logic        w_in_x, w_in_y, w_hit;
  logic [9:0]  w_dx, w_dy, w_addr;

  // 11-bit bounds so x+SPR_W cannot wrap back onto column 0.
  always_comb begin
    w_px    = {1'b0, i_px};
    w_vc    = {1'b0, i_vcount};
    w_x_end = {1'b0, i_regs.x} + 11'(SPR_W);
    w_y_end = {1'b0, i_regs.y} + 11'(SPR_H);
    w_in_x  = (w_px >= {1'b0, i_regs.x}) && (w_px < w_x_end) && (w_px < 11'(HACTIVE_PX));
    w_in_y  = (w_vc >= {1'b0, i_regs.y}) && (w_vc < w_y_end) && (w_vc < 11'(VACTIVE));
    w_hit   = i_regs.en && w_in_x && w_in_y;
    w_dx    = i_px - i_regs.x;
    w_dy    = i_vcount - i_regs.y;
    w_addr  = w_dx + w_dy * 10'(SPR_W);
  end

  // Register hit flag; ROM address only advances on a hit so it holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_hit      <= 1'b0;
      o_rom_addr <= '0;
    end else begin
      o_hit <= w_hit;
      if (w_hit) o_rom_addr <= w_addr;
    end
  end

endmodule

// File: rtl/sprite_compositor_ctrl.sv
// Sprite scheduler/compositor: staged register bank committed at the start of
// vertical blank, per-sprite ROM addressing, priority/transparency resolve.
// hcount -> pix latency is 3 clocks.
module sprite_compositor_ctrl
  import vga_sprite_pkg::*;
#(
  parameter int          NSPR  = 4,
  parameter int          SPR_W = 32,
  parameter int          SPR_H = 32,
  parameter logic [15:0] KEY   = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  sprite_compositor_ctrl_if.slave bus,
  input  logic [10:0]            hcount,
  input  logic [9:0]             vcount,
  input  logic                   blank_n,
  output logic [NSPR-1:0][9:0]   rom_addr,
  input  logic [NSPR-1:0][15:0]  rom_data,
  output logic [7:0]             pix_r,
  output logic [7:0]             pix_g,
  output logic [7:0]             pix_b,
  output logic                   frame_tick,
  output logic                   pending
);

  sprite_regs_t [NSPR-1:0] r_stage, r_active;
  logic [23:0]             r_bg_stage, r_bg_active;
  logic                    r_frame_tick, r_pending;
  logic                    r_blank_d1, r_blank_d2;
  logic [NSPR-1:0]         r_hit_d2;
  logic [23:0]             r_pix;

  logic                    w_commit, w_wr, w_wr_valid;
  logic [NSPR-1:0]         w_hit;
  logic [23:0]             w_pix;

  // Commit strobe and write decode; unmapped addresses must not touch pending.
  always_comb begin
    w_commit   = (hcount == 11'd0) && (vcount == 10'(VACTIVE));
    w_wr       = bus.chipselect && bus.write;
    w_wr_valid = w_wr && ((bus.address == BG_ADDR) ||
                          ((bus.address < 9'(4*NSPR)) && (bus.address[1:0] != 2'd3)));
  end

  // Staging bank: only the bus writes here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stage    <= '0;
      r_bg_stage <= 24'hFFFFFF;
    end else if (w_wr) begin
      if (bus.address == BG_ADDR) r_bg_stage <= bus.writedata[23:0];
      for (int i = 0; i < NSPR; i++) begin
        if (bus.address[8:2] == 7'(i)) begin
          case (bus.address[1:0])
            SPR_X:    r_stage[i].x  <= bus.writedata[9:0];
            SPR_Y:    r_stage[i].y  <= bus.writedata[9:0];
            SPR_CTRL: r_stage[i].en <= bus.writedata[0];
            default:  ;
          endcase
        end
      end
    end
  end

  // Active bank: copies the pre-write staging contents on the commit cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active    <= '0;
      r_bg_active <= 24'hFFFFFF;
    end else if (w_commit) begin
      r_active    <= r_stage;
      r_bg_active <= r_bg_stage;
    end
  end

  // Commit pulse and pending flag; a write on the commit cycle keeps pending set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_tick <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_frame_tick <= w_commit;
      if (w_wr_valid)    r_pending <= 1'b1;
      else if (w_commit) r_pending <= 1'b0;
    end
  end

  for (genvar g = 0; g < NSPR; g++) begin : g_hit
    sprite_hit_unit #(.SPR_W(SPR_W), .SPR_H(SPR_H)) u_hit (
      .clk        (clk),
      .reset      (reset),
      .i_px       (hcount[10:1]),
      .i_vcount   (vcount),
      .i_regs     (r_active[g]),
      .o_hit      (w_hit[g]),
      .o_rom_addr (rom_addr[g])
    );
  end

  // Delay blank and hit flags to line up with ROM data (stage 2).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_blank_d1 <= 1'b0;
      r_blank_d2 <= 1'b0;
      r_hit_d2   <= '0;
    end else begin
      r_blank_d1 <= blank_n;
      r_blank_d2 <= r_blank_d1;
      r_hit_d2   <= w_hit;
    end
  end

  // Priority resolve: scan high to low so the lowest opaque index wins.
  always_comb begin
    w_pix = r_bg_active;
    for (int i = NSPR-1; i >= 0; i--) begin
      if (r_hit_d2[i] && (rom_data[i] != KEY)) w_pix = rgb565_to_888(rom_data[i]);
    end
  end

  // Output pixel register (stage 3), forced black during blanking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pix <= '0;
    else        r_pix <= r_blank_d2 ? w_pix : 24'h000000;
  end

  assign {pix_r, pix_g, pix_b} = r_pix;
  assign frame_tick = r_frame_tick;
  assign pending    = r_pending;

endmodule

// File: tb/tb_sprite_compositor_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with the
// cycle they are due; a negedge monitor pops and compares them.
module tb_sprite_compositor_ctrl;
  import vga_sprite_pkg::*;

  localparam int NSPR = 4;
  localparam int K_PIX = 0, K_ADDR = 1, K_FT = 2, K_PEND = 3;
  localparam int GREEN = 24'h00FC00, RED = 24'hF80000, BLUE = 24'h0000F8;
  localparam int WHITE = 24'hFFFFFF, BG2 = 24'h123456;

  logic clk = 1'b0;
  logic reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        blank_n;
  logic [NSPR-1:0][9:0]  rom_addr;
  logic [NSPR-1:0][15:0] rom_data;
  logic [15:0] rom_val [NSPR];
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        frame_tick, pending;

  sprite_compositor_ctrl_if bus_if ();

  sprite_compositor_ctrl #(.NSPR(NSPR)) dut (
    .clk(clk), .reset(reset), .bus(bus_if),
    .hcount(hcount), .vcount(vcount), .blank_n(blank_n),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  // ROM model with one-cycle read latency; each sprite returns a fixed colour.
  always @(posedge clk) for (int i = 0; i < NSPR; i++) rom_data[i] <= rom_val[i];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          kind;
    logic [1:0]  idx;
    logic [23:0] val;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [23:0] actual(input int kind, input logic [1:0] idx);
    case (kind)
      K_PIX:   return {pix_r, pix_g, pix_b};
      K_ADDR:  return 24'(rom_addr[idx]);
      K_FT:    return 24'(frame_tick);
      default: return 24'(pending);
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_PIX:   return "pix";
      K_ADDR:  return "rom_addr";
      K_FT:    return "frame_tick";
      default: return "pending";
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    int k;
    logic [23:0] act;
    k = 0;
    while (k < q.size()) begin
      if (q[k].due <= cyc) begin
        act = actual(q[k].kind, q[k].idx);
        checks++;
        if (q[k].due < cyc || act !== q[k].val) begin
          errors++;
          $display("FAIL %s[%0d] cycle %0d (due %0d): got %h, want %h",
                   kname(q[k].kind), q[k].idx, cyc, q[k].due, act, q[k].val);
        end
        q.delete(k);
      end else begin
        k++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int idx, input int val, input int lat);
    exp_t e;
    e.due  = cyc + lat;
    e.kind = kind;
    e.idx  = 2'(idx);
    e.val  = 24'(val);
    q.push_back(e);
  endtask

  task automatic set_px(input int px, input int v, input logic bl);
    hcount  = 11'(px * 2);
    vcount  = 10'(v);
    blank_n = bl;
  endtask

  task automatic pix(input int px, input int v, input int exp_pix);
    set_px(px, v, 1'b1);
    push(K_PIX, 0, exp_pix, 3);
    tick();
  endtask

  task automatic pixa(input int px, input int v, input int exp_pix, input int idx, input int exp_addr);
    set_px(px, v, 1'b1);
    push(K_PIX, 0, exp_pix, 3);
    push(K_ADDR, idx, exp_addr, 1);
    tick();
  endtask

  task automatic wr(input int a, input int d);
    bus_if.chipselect = 1'b1;
    bus_if.write      = 1'b1;
    bus_if.address    = 9'(a);
    bus_if.writedata  = 32'(d);
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
  endtask

  task automatic commit(input int exp_pend);
    set_px(0, 480, 1'b0);
    push(K_FT, 0, 1, 1);
    push(K_PEND, 0, exp_pend, 1);
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
    set_px(1, 480, 1'b0);
    push(K_FT, 0, 0, 1);
    tick();
  endtask

  // Let in-flight pixels drain before the ROM colour changes.
  task automatic set_rom(input int i, input logic [15:0] v);
    repeat (3) tick();
    rom_val[i] = v;
  endtask

  initial begin
    reset = 1'b0;
    bus_if.chipselect = 1'b0;
    bus_if.write      = 1'b0;
    bus_if.address    = '0;
    bus_if.writedata  = '0;
    set_px(700, 10, 1'b0);
    rom_val[0] = 16'h07E0;
    rom_val[1] = 16'hF800;
    rom_val[2] = 16'h001F;
    rom_val[3] = 16'hFFFF;

    // Reset state
    tick(); tick();
    push(K_PIX, 0, 0, 0);
    push(K_ADDR, 0, 0, 0);
    push(K_PEND, 0, 0, 0);
    push(K_FT, 0, 0, 0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL pending after reset: got %b, want 0", pending);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL frame_tick after reset: got %b, want 0", frame_tick);
    end
    set_px(700, 10, 1'b0);
    push(K_PIX, 0, 0, 3);
    tick();
    pix(10, 10, WHITE);
    pix(320, 240, WHITE);
    push(K_PEND, 0, 0, 0);
    tick();

    // Staged write, not visible until commit
    wr(0, 100);
    push(K_PEND, 0, 1, 0);
    wr(1, 50);
    wr(2, 1);
    pix(100, 50, WHITE);
    pix(115, 60, WHITE);
    commit(0);
    checks++;
    if (pending !== 1'b0) begin
      errors++;
      $display("FAIL pending after commit: got %b, want 0", pending);
    end
    pixa(100, 50, GREEN, 0, 0);
    pixa(131, 81, GREEN, 0, 1023);
    pixa(132, 81, WHITE, 0, 1023);
    pix(99, 50, WHITE);
    pix(100, 82, WHITE);
    pixa(115, 60, GREEN, 0, 335);

    // Priority and transparency with sprite 1 overlapping sprite 0
    wr(4, 110);
    wr(5, 55);
    wr(6, 1);
    commit(0);
    set_rom(0, 16'hFFFF);
    pix(115, 60, RED);
    pix(105, 52, WHITE);
    pix(140, 60, RED);
    set_rom(0, 16'h001F);
    pix(115, 60, BLUE);
    pix(105, 52, BLUE);
    set_rom(0, 16'h07E0);

    // Write landing on the commit cycle
    bus_if.chipselect = 1'b1;
    bus_if.write      = 1'b1;
    bus_if.address    = 9'd1;
    bus_if.writedata  = 32'd200;
    commit(1);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL pending after commit-cycle write: got %b, want 1", pending);
    end
    pix(100, 50, GREEN);
    pix(100, 200, WHITE);
    push(K_PEND, 0, 1, 0);
    tick();
    commit(0);
    pix(100, 50, WHITE);
    pix(100, 200, GREEN);

    // Unmapped addresses have no side effect
    wr(3, 5);
    wr(33, 7);
    wr(511, 1);
    push(K_PEND, 0, 0, 0);
    tick();
    commit(0);
    pix(100, 200, GREEN);
    pix(5, 5, WHITE);

    // Right-edge clipping and new background
    wr(8, 630);
    wr(9, 300);
    wr(10, 1);
    wr(32, BG2);
    commit(0);
    pixa(630, 300, BLUE, 2, 0);
    pixa(639, 300, BLUE, 2, 9);
    set_px(640, 300, 1'b0);
    push(K_PIX, 0, 0, 3);
    push(K_ADDR, 2, 9, 1);
    tick();
    pixa(0, 301, BG2, 2, 9);
    pixa(21, 301, BG2, 2, 9);
    pixa(629, 301, BG2, 2, 9);
    pixa(630, 301, BLUE, 2, 32);

    // Exact 3-clock latency across the sprite's left edge
    pix(98, 210, BG2);
    pix(99, 210, BG2);
    pixa(100, 210, GREEN, 0, 320);
    pixa(101, 210, GREEN, 0, 321);

    // Mid-frame reset clears pipeline and registers immediately
    wr(0, 5);
    repeat (3) tick();
    reset = 1'b0;
    push(K_PIX, 0, 0, 0);
    push(K_ADDR, 0, 0, 0);
    push(K_PEND, 0, 0, 0);
    tick();
    checks++;
    if ({pix_r, pix_g, pix_b} !== 24'h000000) begin
      errors++;
      $display("FAIL pix during mid-frame reset: got %h, want 000000", {pix_r, pix_g, pix_b});
    end
    checks++;
    if (rom_addr[0] !== 10'd0) begin
      errors++;
      $display("FAIL rom_addr[0] during mid-frame reset: got %h, want 000", rom_addr[0]);
    end
    tick();
    reset = 1'b1;
    pixa(100, 210, WHITE, 0, 0);
    pix(101, 210, WHITE);

    repeat (10) tick();
    for (int k = 0; k < q.size(); k++) begin
      errors++;
      $display("FAIL %s[%0d] never compared (due %0d): got none, want %h",
               kname(q[k].kind), q[k].idx, q[k].due, q[k].val);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
